// File: rtl/dict_pool.sv
// Byte-wide dictionary RAM with 1/2/4-byte little-endian access and a
// hardware FIND that walks the linked Forth dictionary from the latest entry.
module dict_pool #(
  parameter int         ASZ  = 17,
  parameter int         LNK  = 3,
  parameter logic [7:0] LMSK = 8'h1f,
  parameter bit         CI   = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic [3:0]     op,
  input  logic [ASZ-1:0] ai,
  input  logic [31:0]    vi,
  output logic [31:0]    vo,
  output logic           bsy,
  output logic           ack,
  output logic           hit,
  output logic [ASZ-1:0] ao,
  output logic [ASZ-1:0] lat
);

  localparam int DEPTH = 1 << ASZ;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_RD   = 4'd1;
  localparam logic [3:0] S_WR   = 4'd2;
  localparam logic [3:0] S_KLEN = 4'd3;
  localparam logic [3:0] S_KCAP = 4'd4;
  localparam logic [3:0] S_TEST = 4'd5;
  localparam logic [3:0] S_ELEN = 4'd6;
  localparam logic [3:0] S_CK   = 4'd7;
  localparam logic [3:0] S_CE   = 4'd8;
  localparam logic [3:0] S_CC   = 4'd9;
  localparam logic [3:0] S_LINK = 4'd10;

  logic [7:0]       r_mem [0:DEPTH-1];
  logic [7:0]       r_rdata;
  logic [3:0]       r_state;
  logic [ASZ-1:0]   r_a;
  logic [ASZ-1:0]   r_p;
  logic [31:0]      r_data;
  logic [2:0]       r_n;
  logic [7:0]       r_cnt;
  logic [7:0]       r_idx;
  logic [7:0]       r_klen;
  logic [7:0]       r_kc;
  logic [8*LNK-1:0] r_lnk;
  logic [31:0]      r_vo;
  logic             r_bsy;
  logic             r_ack;
  logic             r_hit;
  logic [ASZ-1:0]   r_ao;
  logic [ASZ-1:0]   r_lat;

  logic [ASZ-1:0]   w_addr;
  logic             w_we;
  logic [7:0]       w_wdata;
  logic [31:0]      w_rd;
  logic [8*LNK-1:0] w_lnk;
  logic             w_unused_lnk;

  function automatic logic [7:0] f_fold(input logic [7:0] c);
    if (CI && (c >= 8'h61) && (c <= 8'h7a)) begin
      f_fold = c - 8'h20;
    end else begin
      f_fold = c;
    end
  endfunction

  function automatic logic [2:0] f_size(input logic [1:0] sel);
    case (sel)
      2'd1:    f_size = 3'd1;
      2'd2:    f_size = 3'd2;
      2'd3:    f_size = 3'd4;
      default: f_size = 3'd1;
    endcase
  endfunction

  // Bytes enter at the top so an n-byte result ends up right-aligned after a shift.
  assign w_rd  = {r_rdata, r_data[31:8]};
  assign w_lnk = {r_rdata, r_lnk[8*LNK-1:8]};
  assign w_unused_lnk = ^w_lnk;

  // RAM port address/write selection for the current state.
  always_comb begin
    w_addr  = r_a;
    w_we    = 1'b0;
    w_wdata = r_data[7:0];
    case (r_state)
      S_RD:    w_addr = r_a + ASZ'(r_cnt);
      S_WR:    begin
        w_addr = r_a + ASZ'(r_cnt);
        w_we   = 1'b1;
      end
      S_KLEN:  w_addr = r_a;
      S_TEST:  w_addr = r_p + ASZ'(LNK);
      S_CK:    w_addr = r_a + ASZ'(r_idx);
      S_CE:    w_addr = r_p + ASZ'(LNK) + ASZ'(r_idx);
      S_LINK:  w_addr = r_p + ASZ'(r_cnt);
      default: w_addr = r_a;
    endcase
  end

  // Single-port dictionary RAM, registered read, contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_addr] <= w_wdata;
    end
    r_rdata <= r_mem[w_addr];
  end

  // Request handshake, data transfers and the FIND walk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_p     <= '0;
      r_data  <= 32'd0;
      r_n     <= 3'd0;
      r_cnt   <= 8'd0;
      r_idx   <= 8'd0;
      r_klen  <= 8'd0;
      r_kc    <= 8'd0;
      r_lnk   <= '0;
      r_vo    <= 32'd0;
      r_bsy   <= 1'b0;
      r_ack   <= 1'b0;
      r_hit   <= 1'b0;
      r_ao    <= '0;
      r_lat   <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req && !r_bsy) begin
            case (op)
              4'd1, 4'd2, 4'd3: begin
                r_a     <= ai;
                r_n     <= f_size(op[1:0]);
                r_cnt   <= 8'd0;
                r_data  <= 32'd0;
                r_bsy   <= 1'b1;
                r_state <= S_RD;
              end
              4'd5, 4'd6, 4'd7: begin
                r_a     <= ai;
                r_n     <= f_size(op[1:0]);
                r_cnt   <= 8'd0;
                r_data  <= vi;
                r_bsy   <= 1'b1;
                r_state <= S_WR;
              end
              4'd4: begin
                r_a     <= ai;
                r_p     <= r_lat;
                r_hit   <= 1'b0;
                r_bsy   <= 1'b1;
                r_state <= S_KLEN;
              end
              4'd8: begin
                r_lat <= ai;
                r_ack <= 1'b1;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
        S_RD: begin
          if (r_cnt != 8'd0) begin
            r_data <= w_rd;
          end
          if (r_cnt == {5'd0, r_n}) begin
            r_vo    <= w_rd >> {3'd4 - r_n, 3'b000};
            r_bsy   <= 1'b0;
            r_ack   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WR: begin
          r_data <= r_data >> 8;
          if (r_cnt == ({5'd0, r_n} - 8'd1)) begin
            r_bsy   <= 1'b0;
            r_ack   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_KLEN: r_state <= S_KCAP;
        S_KCAP: begin
          r_klen  <= r_rdata & LMSK;
          r_state <= S_TEST;
        end
        S_TEST: begin
          if (r_p == '0) begin
            r_hit   <= 1'b0;
            r_ao    <= '0;
            r_bsy   <= 1'b0;
            r_ack   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_ELEN;
          end
        end
        S_ELEN: begin
          if ((r_rdata & LMSK) != r_klen) begin
            r_cnt   <= 8'd0;
            r_state <= S_LINK;
          end else if (r_klen == 8'd0) begin
            r_hit   <= 1'b1;
            r_ao    <= r_p;
            r_bsy   <= 1'b0;
            r_ack   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= 8'd1;
            r_state <= S_CK;
          end
        end
        S_CK: r_state <= S_CE;
        S_CE: begin
          r_kc    <= r_rdata;
          r_state <= S_CC;
        end
        S_CC: begin
          if (f_fold(r_kc) != f_fold(r_rdata)) begin
            r_cnt   <= 8'd0;
            r_state <= S_LINK;
          end else if (r_idx == r_klen) begin
            r_hit   <= 1'b1;
            r_ao    <= r_p;
            r_bsy   <= 1'b0;
            r_ack   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= S_CK;
          end
        end
        S_LINK: begin
          r_lnk <= w_lnk;
          if (r_cnt == 8'(LNK)) begin
            r_p     <= w_lnk[ASZ-1:0];
            r_state <= S_TEST;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_bsy   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign vo  = r_vo;
  assign bsy = r_bsy;
  assign ack = r_ack;
  assign hit = r_hit;
  assign ao  = r_ao;
  assign lat = r_lat;

endmodule
